aes_decrypt_iter: RTL
=====================

Name: aes_decrypt_iter

Overview:
- Iterative AES-128 decryption core: one 128-bit ciphertext block and one 128-bit cipher key in, the 128-bit plaintext out.
- It is the inverse counterpart of the team's iterative AES-128 encryption core and shares the same byte and bit ordering, so the two cores round-trip a block.
- Round keys are expanded internally first, then applied in reverse order, one round per clock.
- A start/busy/done handshake replaces level-enable sequencing.

Parameters:
KEY_CACHE, 1, when 1 the core skips key expansion if the key equals the key last expanded successfully; when 0 it always expands.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
ciphertext  input  [0:127]  input block; bit 0 is the MSB; byte k is bits [8k:8k+7]; FIPS-197 input order
key  input  [0:127]  cipher key, same ordering
plaintext  output  [0:127]  result register, same ordering
busy  output  1  high while a block is in flight
done  output  1  one-cycle pulse when plaintext is updated

Behaviour:
- Reset: plaintext=0, busy=0, done=0, state=IDLE, key-cache-valid=0. Reset wins over every other event at the same edge, including mid-operation; a partial result is never written.
- State mapping: state byte s[r][c] = input byte 4c+r, column-major, per FIPS-197. The output uses the same mapping.
- Rounds are numbered 0..10 throughout, and rk[r] denotes round key r.
- IDLE, edge E0 with start=1:
  - Latch ciphertext and key, and set rk[0] = key.
  - If KEY_CACHE=1, cache valid, and key equals the cached key: go to ADDKEY.
  - Otherwise go to KEYEXP with counter=1.
  - busy goes to 1.
  - In IDLE with start=0, nothing changes.
- KEYEXP, 10 cycles:
  - On each edge, compute rk[i] from rk[i-1] using RotWord, SubWord and Rcon[i]. Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - Store rk[1..10] in an 11x128 register bank and increment the counter.
  - After rk[10], set cache-valid=1, store the cached key, and go to ADDKEY.
- ADDKEY, 1 cycle: state = ciphertext XOR rk[10]; set r=9; go to ROUND.
- ROUND, 9 cycles, r = 9 down to 1:
  - state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])).
  - Decrement r.
  - After r=1, go to FINAL.
- FINAL, 1 cycle:
  - plaintext = AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]).
  - done=1 for exactly the following cycle; busy=0; go to IDLE.
- Latency, from the start edge E0 to the edge that writes plaintext:
  - 21 edges with expansion.
  - 11 edges on a cache hit.
  - done is high during the cycle after that edge.
- Back-to-back operation: start may be high during the done cycle, and it is accepted; done and the new busy then coexist for that one cycle.
- start while busy=1 is ignored; ciphertext and key changes while busy have no effect.
- Output stability: plaintext holds its value until the next FINAL or reset.
- Cache invalidation: reset mid-KEYEXP leaves cache-valid=0, so no partially expanded key is ever reused.
- Implementation: InvSubBytes uses 16 combinational inverse S-box instances; the key schedule uses 4 forward S-box instances. There are no other multicycle paths.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> plaintext 00112233445566778899aabbccddeeff; done exactly 21 edges after the start edge; busy high for 21 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
  - Then restart with the same key and ciphertext -> same plaintext with done after 11 edges (KEY_CACHE=1), or 21 edges (KEY_CACHE=0).
- Busy rejection: hold start=1 and change ciphertext to all-ones during busy -> only one done pulse, and the result equals the first-latched block's plaintext.
- Reset mid-operation: assert reset at edge 15 of a C.1 run -> plaintext=0, busy=0, done=0 next cycle.
  - Then a C.1 restart must take the full 21 edges (cache invalid) and produce the correct plaintext.
- Round-trip: 1000 random key/plaintext pairs are encrypted by the team's encryption core, then decrypted by this core -> each recovered plaintext equals the original.
  - Issue each new start during the previous done cycle to exercise back-to-back acceptance.

Source files
------------

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption: expands round keys, then runs one inverse round per clock.
// Latency: 21 edges from accepted start to plaintext write (11 when the key cache hits).
// Backpressure: start is taken only in IDLE; while busy, start/ciphertext/key are ignored.
module aes_decrypt_iter #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] ciphertext,
  input  logic [0:127] key,
  output logic [0:127] plaintext,
  output logic         busy,
  output logic         done
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL} state_t;

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return INV_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One key-schedule step: the four forward S-boxes live here.
  function automatic logic [0:127] key_step(input logic [0:127] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = prev[0 +: 32];
    w1 = prev[32 +: 32];
    w2 = prev[64 +: 32];
    w3 = prev[96 +: 32];
    t  = {sbox_fwd(w3[23:16]) ^ rc, sbox_fwd(w3[15:8]), sbox_fwd(w3[7:0]), sbox_fwd(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows then InvSubBytes; row r rotates right by r, one inverse S-box per byte.
  function automatic logic [0:127] inv_shift_sub(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = sbox_inv(s[8*(4*((c - r) & 3) + r) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    logic [7:0]   m9 [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[8*(4*c+r) +: 8];
        x2[r] = xtime(a[r]);
        x4[r] = xtime(x2[r]);
        x8[r] = xtime(x4[r]);
        m9[r] = x8[r] ^ a[r];
      end
      // Row r output: 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3].
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = (m9[r] ^ x4[r] ^ x2[r] ^ a[r])
                          ^ (m9[(r+1)%4] ^ x2[(r+1)%4])
                          ^ (m9[(r+2)%4] ^ x4[(r+2)%4])
                          ^ m9[(r+3)%4];
      end
    end
    return o;
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         cache_vld_q, cache_vld_d;
  logic [0:127] pt_q, pt_d;
  logic [0:127] st_q, st_d;
  logic [0:127] rk_q [0:10];
  logic [0:127] rk_d [0:10];
  logic [0:127] ark;

  // Shared tail of the inverse round: rows, S-boxes and the current round key.
  assign ark = inv_shift_sub(st_q) ^ rk_q[cnt_q];

  // Next-state and datapath updates. rk_q[0] doubles as the cached key: a miss
  // clears cache_vld, so whenever cache_vld is set rk_q[1..10] belong to rk_q[0].
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cache_vld_d = cache_vld_q;
    pt_d        = pt_q;
    st_d        = st_q;
    rk_d        = rk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = ciphertext;
          rk_d[0] = key;
          busy_d  = 1'b1;
          if ((KEY_CACHE != 0) && cache_vld_q && (key == rk_q[0])) begin
            state_d = ADDKEY;
          end else begin
            state_d     = KEYEXP;
            cnt_d       = 4'd1;
            cache_vld_d = 1'b0;
          end
        end
      end
      KEYEXP: begin
        rk_d[cnt_q] = key_step(rk_q[cnt_q - 4'd1], rcon(cnt_q));
        if (cnt_q == 4'd10) begin
          cache_vld_d = 1'b1;
          state_d     = ADDKEY;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ADDKEY: begin
        st_d    = st_q ^ rk_q[10];
        cnt_d   = 4'd9;
        state_d = ROUND;
      end
      ROUND: begin
        st_d  = inv_mix(ark);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        pt_d    = ark;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset overrides any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cache_vld_q <= 1'b0;
      pt_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cache_vld_q <= cache_vld_d;
      pt_q        <= pt_d;
    end
  end

  // Working state and round-key bank; contents are only trusted via the FSM.
  always_ff @(posedge clk) begin
    st_q <= st_d;
    rk_q <= rk_d;
  end

  assign plaintext = pt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
